// File: rtl/dmux_pkg.sv
// Shared constants for the dmux sequencing controller: round-robin pointer
// states, destination codes and mode codes.
package dmux_pkg;

    typedef enum logic {
        ST_NEXT1 = 1'b0,
        ST_NEXT2 = 1'b1
    } rr_state_e;

    localparam logic DEST_OUT1 = 1'b0;
    localparam logic DEST_OUT2 = 1'b1;

    localparam logic MODE_RR   = 1'b0;
    localparam logic MODE_DEST = 1'b1;

endpackage : dmux_pkg

// File: rtl/dmux.sv
// N-bit 1-to-2 data demultiplexer: routes data to out1 (sel=0) or out2 (sel=1);
// the unselected output is driven to zero.
module dmux #(
    parameter int N = 3
) (
    input  logic [N-1:0] data,
    input  logic         sel,
    output logic [N-1:0] out1,
    output logic [N-1:0] out2
);

    assign out1 = sel ? '0 : data;
    assign out2 = sel ? data : '0;

endmodule : dmux

// File: rtl/dmux_ctrl.sv
// Sequencing controller for the 1-to-2 dmux: round-robin or explicit routing
// into two registered output slots. Optional per-output delivery counters are
// built when DMUX_CTRL_STATS_EN is defined.
module dmux_ctrl
    import dmux_pkg::*;
#(
    parameter int N  = 3,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_dest,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          mode,
    output logic [N-1:0]  out1_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [N-1:0]  out2_data,
    output logic          out2_valid,
    input  logic          out2_ready,
    output logic          sel
`ifdef DMUX_CTRL_STATS_EN
    ,
    output logic [CW-1:0] cnt1,
    output logic [CW-1:0] cnt2
`endif
);

    if (CW < 1) begin : g_cw_check
        $error("dmux_ctrl: CW must be at least 1");
    end

    rr_state_e    state_q, state_d;
    logic [N-1:0] out1_data_q, out1_data_d;
    logic [N-1:0] out2_data_q, out2_data_d;
    logic         out1_valid_q, out1_valid_d;
    logic         out2_valid_q, out2_valid_d;
    logic         sel_q, sel_d;

    logic         tgt;
    logic         take1, take2;
    logic         accept;
    logic         deliver1, deliver2;
    logic [N-1:0] dm_out1, dm_out2;

    // Round-robin pointer only matters in MODE_RR; explicit mode bypasses it.
    assign tgt = (mode == MODE_DEST) ? in_dest : (state_q == ST_NEXT2);

    assign deliver1 = out1_valid_q & out1_ready;
    assign deliver2 = out2_valid_q & out2_ready;
    assign take1    = !out1_valid_q || out1_ready;
    assign take2    = !out2_valid_q || out2_ready;

    // No skipping: a blocked RR target stalls input even if the other slot is free.
    assign in_ready = (tgt == DEST_OUT2) ? take2 : take1;
    assign accept   = in_valid & in_ready;

    dmux #(.N(N)) u_dmux (
        .data (in_data),
        .sel  (tgt),
        .out1 (dm_out1),
        .out2 (dm_out2)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d      = state_q;
        out1_data_d  = out1_data_q;
        out2_data_d  = out2_data_q;
        out1_valid_d = out1_valid_q;
        out2_valid_d = out2_valid_q;
        sel_d        = sel_q;

        if (deliver1) out1_valid_d = 1'b0;
        if (deliver2) out2_valid_d = 1'b0;

        if (accept) begin
            sel_d = tgt;
            if (tgt == DEST_OUT1) begin
                out1_data_d  = dm_out1;
                out1_valid_d = 1'b1;
            end else begin
                out2_data_d  = dm_out2;
                out2_valid_d = 1'b1;
            end
            if (mode == MODE_RR) begin
                state_d = (state_q == ST_NEXT1) ? ST_NEXT2 : ST_NEXT1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q      <= ST_NEXT1;
            out1_data_q  <= '0;
            out2_data_q  <= '0;
            out1_valid_q <= 1'b0;
            out2_valid_q <= 1'b0;
            sel_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            out1_data_q  <= out1_data_d;
            out2_data_q  <= out2_data_d;
            out1_valid_q <= out1_valid_d;
            out2_valid_q <= out2_valid_d;
            sel_q        <= sel_d;
        end
    end

    assign out1_data  = out1_data_q;
    assign out2_data  = out2_data_q;
    assign out1_valid = out1_valid_q;
    assign out2_valid = out2_valid_q;
    assign sel        = sel_q;

`ifdef DMUX_CTRL_STATS_EN
    logic [CW-1:0] cnt1_q, cnt1_d;
    logic [CW-1:0] cnt2_q, cnt2_d;

    // Counters wrap naturally modulo 2^CW.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (deliver1) cnt1_d = cnt1_q + 1'b1;
        if (deliver2) cnt2_d = cnt2_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign cnt1 = cnt1_q;
    assign cnt2 = cnt2_q;
`endif

endmodule : dmux_ctrl

// File: tb/tb_dmux_ctrl.sv
// Directed self-checking bench for dmux_ctrl; covers the counter wrap when
// DMUX_CTRL_STATS_EN is defined.
module tb_dmux_ctrl;
    import dmux_pkg::*;

    localparam int N  = 3;
    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic [N-1:0]  in_data;
    logic          in_dest;
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [N-1:0]  out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [N-1:0]  out2_data;
    logic          out2_valid;
    logic          out2_ready;
    logic          sel;
`ifdef DMUX_CTRL_STATS_EN
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
`endif

    int total = 0;
    int bad   = 0;

    dmux_ctrl #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out2_data  (out2_data),
        .out2_valid (out2_valid),
        .out2_ready (out2_ready),
        .sel        (sel)
`ifdef DMUX_CTRL_STATS_EN
        ,
        .cnt1       (cnt1),
        .cnt2       (cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        in_data    = '0;
        in_dest    = 1'b0;
        in_valid   = 1'b0;
        mode       = MODE_RR;
        out1_ready = 1'b0;
        out2_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-stream: out1 holds 3'b101, then asynchronous reset
        in_valid = 1'b1; in_data = 3'b101;
        step();
        in_valid = 1'b0;
        check("pre_rst_o1v", 32'(out1_valid), 32'd1);
        check("pre_rst_o1d", 32'(out1_data), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("rst_o1v", 32'(out1_valid), 32'd0);
        check("rst_o2v", 32'(out2_valid), 32'd0);
        check("rst_o1d", 32'(out1_data), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_fsm", 32'(dut.state_q), 32'(ST_NEXT1));
`ifdef DMUX_CTRL_STATS_EN
        check("rst_cnt1", 32'(cnt1), 32'd0);
        check("rst_cnt2", 32'(cnt2), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        // RR streaming 1,2,3,4 with both consumers ready
        mode = MODE_RR; out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; in_dest = 1'b1;
        in_data = 3'd1; settle();
        check("rr_rdy1", 32'(in_ready), 32'd1);
        step();
        check("rr_w1_o1v", 32'(out1_valid), 32'd1);
        check("rr_w1_o1d", 32'(out1_data), 32'd1);
        check("rr_w1_sel", 32'(sel), 32'd0);
        in_data = 3'd2; settle();
        check("rr_rdy2", 32'(in_ready), 32'd1);
        step();
        check("rr_w2_o2v", 32'(out2_valid), 32'd1);
        check("rr_w2_o2d", 32'(out2_data), 32'd2);
        check("rr_w2_o1v", 32'(out1_valid), 32'd0);
        check("rr_w2_sel", 32'(sel), 32'd1);
        in_data = 3'd3; settle();
        check("rr_rdy3", 32'(in_ready), 32'd1);
        step();
        check("rr_w3_o1d", 32'(out1_data), 32'd3);
        check("rr_w3_o1v", 32'(out1_valid), 32'd1);
        check("rr_w3_o2v", 32'(out2_valid), 32'd0);
        in_data = 3'd4; settle();
        check("rr_rdy4", 32'(in_ready), 32'd1);
        step();
        check("rr_w4_o2d", 32'(out2_data), 32'd4);
        check("rr_w4_o2v", 32'(out2_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("rr_drain_o1v", 32'(out1_valid), 32'd0);
        check("rr_drain_o2v", 32'(out2_valid), 32'd0);
        check("rr_hold_o2d", 32'(out2_data), 32'd4);

        // RR stall: out1 blocked, word 7 must wait for it despite slot 2 being free
        out1_ready = 1'b0; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 3'd5;
        step();
        check("st_w5_o1d", 32'(out1_data), 32'd5);
        in_data = 3'd6; settle();
        check("st_rdy6", 32'(in_ready), 32'd1);
        step();
        check("st_w6_o2d", 32'(out2_data), 32'd6);
        check("st_w6_o2v", 32'(out2_valid), 32'd1);
        in_data = 3'd7; settle();
        check("st_rdy7_blk", 32'(in_ready), 32'd0);
        step();
        check("st_o2_drained", 32'(out2_valid), 32'd0);
        check("st_rdy7_still", 32'(in_ready), 32'd0);
        check("st_o1_held", 32'(out1_data), 32'd5);
        out1_ready = 1'b1; settle();
        check("st_rdy7_open", 32'(in_ready), 32'd1);
        step();
        check("st_w7_o1d", 32'(out1_data), 32'd7);
        check("st_w7_o1v", 32'(out1_valid), 32'd1);
        check("st_w7_sel", 32'(sel), 32'd0);
        // One more RR word (goes to out2) returns the pointer to NEXT1
        in_data = 3'd0;
        step();
        check("st_w0_o2v", 32'(out2_valid), 32'd1);
        check("st_w0_o2d", 32'(out2_data), 32'd0);
        in_valid = 1'b0;
        step();

        // Explicit destination: three words to out2
        mode = MODE_DEST; in_dest = DEST_OUT2; out2_ready = 1'b1;
        in_valid = 1'b1; in_data = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step();
            check("ex_o2v", 32'(out2_valid), 32'd1);
            check("ex_o2d", 32'(out2_data), 32'd3);
            check("ex_sel", 32'(sel), 32'd1);
            check("ex_o1v", 32'(out1_valid), 32'd0);
        end
        // Back to RR with in_dest still 1: pointer is NEXT1 so word goes to out1
        mode = MODE_RR; in_data = 3'd6;
        step();
        check("ex_rr_o1v", 32'(out1_valid), 32'd1);
        check("ex_rr_o1d", 32'(out1_data), 32'd6);
        check("ex_rr_sel", 32'(sel), 32'd0);
        in_valid = 1'b0;
        step();

        // Hold stability: out2 stalled with data 2 for 10 cycles
        mode = MODE_DEST; in_dest = DEST_OUT2; out2_ready = 1'b0;
        in_valid = 1'b1; in_data = 3'd2;
        step();
        check("hd_o2v", 32'(out2_valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = 3'(i + 3);
            settle();
            check("hd_rdy", 32'(in_ready), 32'd0);
            step();
            check("hd_o2d", 32'(out2_data), 32'd2);
            check("hd_o2v_keep", 32'(out2_valid), 32'd1);
        end
        in_valid = 1'b0; out2_ready = 1'b1;
        step();
        check("hd_release", 32'(out2_valid), 32'd0);

`ifdef DMUX_CTRL_STATS_EN
        // Counter wrap: reset, then 256 deliveries on out1
        rst = 1'b1;
        #2 rst = 1'b0;
        step();
        mode = MODE_DEST; in_dest = DEST_OUT1; out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_data = 3'(i);
            step();
        end
        check("cnt1_255", 32'(cnt1), 32'd255);
        in_valid = 1'b0;
        step();
        check("cnt1_wrap", 32'(cnt1), 32'd0);
        check("cnt2_idle", 32'(cnt2), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dmux_ctrl

// File: doc/dmux_ctrl.md
Name: dmux_ctrl

Overview:
Sequencing controller for the N-bit 1-to-2 data demultiplexer (`dmux`). It accepts a valid/ready input word stream and chooses the destination per word, either by strict round-robin alternation or by an explicit destination bit. It drives the dmux select and holds one registered word per output with independent valid/ready handshakes. It sits between a single producer and two consumers.

Parameters:
N, 3, data word width (matches dmux N)
CW, 8, width of per-output word counters (stats feature only)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_data  in  N  input word
in_dest  in  1  explicit destination: 0 = out1, 1 = out2; used only when mode=1
in_valid  in  1  producer has a word
in_ready  out  1  controller accepts word this cycle
mode  in  1  0 = round-robin alternation, 1 = explicit in_dest
out1_data  out  N  registered word for consumer 1
out1_valid  out  1  out1_data is valid
out1_ready  in  1  consumer 1 takes word
out2_data  out  N  registered word for consumer 2
out2_valid  out  1  out2_data is valid
out2_ready  in  1  consumer 2 takes word
sel  out  1  select of the last accepted word: 0 = out1, 1 = out2
cnt1  out  CW  words delivered on out1 (only with DMUX_CTRL_STATS_EN)
cnt2  out  CW  words delivered on out2 (only with DMUX_CTRL_STATS_EN)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: out1_valid/out2_valid=0, out1_data/out2_data=0, sel=0, FSM=NEXT1, cnt1/cnt2=0. Reset mid-transfer discards held words without delivering them.
- FSM (round-robin pointer), two states:
  - NEXT1: next RR target is out1.
  - NEXT2: next RR target is out2.
  - Transitions occur only on an accept in mode=0 (NEXT1->NEXT2, NEXT2->NEXT1).
  - In mode=1 the state holds.
- Target: tgt = mode ? in_dest : (state==NEXT2).
- Slot k can take a word when: !outk_valid, or (outk_valid & outk_ready) in the same cycle (pass-through refill).
- in_ready = slot[tgt] can take a word. It is combinational from tgt, outk_valid and outk_ready, and does not depend on in_valid.
- Accept = in_valid & in_ready. On an accept:
  - in_data is steered through the dmux (select=tgt) into slot[tgt].
  - outk_valid=1 on the next edge.
  - sel<=tgt.
- Latency: 1 cycle from accept to out valid. Throughput is 1 word per cycle while the consumer drains every cycle.
- Ordering in round-robin mode is strict. If the RR target slot is full and not draining, input stalls even if the other slot is free (no skipping).
- Drain: outk_valid & outk_ready with no refill clears outk_valid on the next edge. outk_data holds its last value.
- Held data must not change while outk_valid=1 and outk_ready=0.
- Mode change takes effect on the next accept decision (combinational). The RR pointer keeps its value across mode=1 periods.
- in_dest is ignored in mode=0.
- in_data is ignored when there is no accept.
- Both slots can drain in the same cycle, independently.

Optional Feature:
- Macro DMUX_CTRL_STATS_EN.
- Defined:
  - cnt1/cnt2 ports exist.
  - Each counter increments on its output's valid&ready handshake and wraps modulo 2^CW (255 -> 0 at CW=8).
  - Both counters reset to 0.
- Undefined: the ports and counter logic are absent. All other behaviour is identical.

Decomposition:
- Shared package dmux_pkg holds:
  - state encoding constants ST_NEXT1=1'b0, ST_NEXT2=1'b1
  - destination constants DEST_OUT1=1'b0, DEST_OUT2=1'b1
  - mode constants MODE_RR=1'b0, MODE_DEST=1'b1
- Sub-module: instantiate the existing dmux #(N) for the steering path (data, sel=tgt, out1, out2), feeding the slot registers. There are no other sub-modules.

Test Plan:
- Reset: assert rst mid-stream with out1 holding 3'b101 -> out1_valid=0, out2_valid=0, sel=0, FSM=NEXT1 immediately, no clock required. Counters read 0.
- RR streaming: mode=0, both ready=1, send 1,2,3,4 back-to-back -> out1 gets 1,3 and out2 gets 2,4. Each word appears 1 cycle after accept. in_ready stays 1 throughout.
- RR stall: mode=0, out1_ready=0, send 5,6,7 -> 5 is held on out1 and 6 goes to out2. 7 is stalled with in_ready=0 although slot 2 is empty after drain. Raise out1_ready -> 5 delivered and 7 accepted the same cycle into out1.
- Explicit destination: mode=1, send 3'b011 with in_dest=1 three times, out2_ready=1 -> all arrive on out2 and sel=1. Switch to mode=0 -> next word goes to out1 (pointer unchanged at NEXT1).
- Hold stability: out2_valid=1, out2_ready=0 for 10 cycles while in_valid toggles with dest=1 -> out2_data is constant and in_ready=0.
- Stats (DMUX_CTRL_STATS_EN, CW=8): deliver 256 words on out1 -> cnt1 wraps to 0 and cnt2 is unchanged.
